// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and the instruction-buffer entry type for
//               the fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] INSTR_BUBBLE         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP              = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetched {pc, instr} entries with a flush
//               that takes priority over push. FIFO_DEPTH: power of two, >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic                              i_flush,
    input  fetch_entry_t                      i_wr_entry,
    output fetch_entry_t                      o_rd_entry,
    output logic [$clog2(FIFO_DEPTH):0]       o_count,
    output logic                              o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    // A simultaneous pop frees the slot, so push is accepted even when full.
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

    assign o_rd_entry = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_entry;
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : PC owner and instruction fetch front end feeding IF/ID.
//               Define FETCH_PERF_EN to add perf_fetched/perf_bubbles counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jal,
    input  logic        jalr,
    input  logic        branch_out,
    input  logic [31:0] redirect_target,
    input  logic        load,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fetch_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_prev_address
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        r_pc;
    logic [31:0]        r_pend_pc;
    logic               r_outstanding;
    logic               r_drop;

    logic               w_redirect;
    logic [31:0]        w_target;
    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    fetch_entry_t       w_wr_entry;
    fetch_entry_t       w_head;

    assign w_redirect = jal | jalr | branch_out;
    assign w_target   = redirect_target & 32'hFFFF_FFFC;

    // rst_n gating keeps the request low while reset is held.
    assign imem_req_valid = rst_n & ~w_redirect & ~r_outstanding
                          & (w_count < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_push     = imem_rsp_valid & ~r_drop & ~w_redirect;
    assign w_wr_entry = '{pc: r_pend_pc, instr: imem_rsp_data};

    assign fetch_valid     = ~w_empty;
    assign w_pop           = fetch_valid & ~load & ~w_redirect;
    assign instr_out       = w_empty ? INSTR_BUBBLE : w_head.instr;
    assign pc_prev_address = w_empty ? 32'h0 : w_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_VECTOR;
            r_pend_pc     <= RESET_VECTOR;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_req_fire) begin
                r_pc <= r_pc + PC_STEP;
            end

            if (w_req_fire) begin
                r_pend_pc     <= r_pc;
                r_outstanding <= 1'b1;
            end else if (imem_rsp_valid) begin
                r_outstanding <= 1'b0;
            end

            // A response always retires the drop; otherwise a redirect over an
            // in-flight request marks that response as wrong-path.
            if (imem_rsp_valid) begin
                r_drop <= 1'b0;
            end else if (w_redirect && r_outstanding) begin
                r_drop <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (w_redirect),
        .i_wr_entry (w_wr_entry),
        .o_rd_entry (w_head),
        .o_count    (w_count),
        .o_empty    (w_empty)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!fetch_valid && !load && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule : pc_fetch_unit
`default_nettype wire
